phoenix: RTL and testbench
==========================

PHOENIX -- requirements
Module: phoenix

Interface
REQ-001 Parameter RESET_ADDRESS, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter M_EXTENSION, 1'b0, 1 enables RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
REQ-003 Parameter E_EXTENSION, 1'b0, 1 selects RV32E 16-register file.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 instruction_memory_interface_enable  out  1  fetch request.
REQ-007 instruction_memory_interface_state  out  1  READ=0, WRITE=1; fetch always READ.
REQ-008 instruction_memory_interface_address  out  32  byte address = PC.
REQ-009 instruction_memory_interface_frame_mask  out  4  always 4'b1111.
REQ-010 instruction_memory_interface_data  in  32  instruction word.
REQ-011 data_memory_interface_enable  out  1  load/store request.
REQ-012 data_memory_interface_state  out  1  READ=0 load, WRITE=1 store.
REQ-013 data_memory_interface_address  out  32  effective byte address.
REQ-014 data_memory_interface_frame_mask  out  4  byte enables; bit 3 = bits 7:0, bit 0 = bits 31:24.
REQ-015 data_memory_interface_data  inout  32  core drives store data only when enable=1 and state=WRITE, else high-Z.

Function
REQ-016 Memory contract: core holds enable/state/address/mask stable for one full cycle; returned data is valid and sampled at the next rising edge (zero wait states).
REQ-017 Multi-cycle FSM: FETCH -> EXECUTE -> (MEMORY if load/store) -> WRITEBACK -> FETCH; HALT entered after EBREAK writeback.
REQ-018 FETCH: instruction enable=1 for exactly one cycle; instruction latched at end of cycle.
REQ-019 EXECUTE: decode, read rs1/rs2, compute ALU result, branch/jump target; no memory activity.
REQ-020 MEMORY: data enable=1 for exactly one cycle; stores lane-shift data to byte lane addr[1:0] (byte k in bits 8k+7:8k, mask bit 3-k); halfword uses lanes addr[1]*2..+1; word mask 4'b1111.
REQ-021 Loads extract byte/halfword from lane addr[1:0] and sign/zero-extend per LB/LH/LBU/LHU; low address bits ignored for LW/SW (no misalignment trap).
REQ-022 WRITEBACK: write rd (x0 never written), update PC (PC+4, branch/JAL/JALR target with bit0 cleared), latch opcode_MW_reg (7b) and funct12_MW_reg (12b), increment minstret.
REQ-023 Full RV32I base set executed; FENCE/ECALL = no-op; unknown opcodes = no-op that retires.
REQ-024 M ops: 32x32 multiply combinational; DIV/REM by zero -> quotient all-ones, remainder = dividend; -2^31/-1 -> quotient -2^31, remainder 0; with M_EXTENSION=0 M ops are no-ops.
REQ-025 E_EXTENSION=1: x16-x31 read as 0, writes ignored.
REQ-026 Zicsr CSRRW/S/C and immediate forms on mcycle/mcycleh, minstret/minstreth (64-bit counters), alucsr 0x800, mulcsr 0x801, divcsr 0x802 (32-bit R/W); other CSRs read 0.
REQ-027 mcycle increments every cycle reset is low, including HALT.
REQ-028 EBREAK: retires, opcode_MW_reg=SYSTEM, funct12_MW_reg=12'h001, then HALT: both enables 0, state frozen until reset.

Reset
REQ-029 While reset=1 at a rising edge: PC=RESET_ADDRESS, FSM=FETCH next cycle, all enables 0, data bus high-Z, registers and CSRs 0, opcode_MW_reg/funct12_MW_reg 0.
REQ-030 Reset mid-operation aborts the instruction with no register or memory write after that edge.

Structure
REQ-031 Shared package/include: opcode constants (incl. SYSTEM), funct12 EBREAK, READ/WRITE, ENABLE/DISABLE, CSR addresses.
REQ-032 Sub-modules: register_file instance named register_file (array Registers[0:31]), control_status_register_file (alucsr_reg, mulcsr_reg, divcsr_reg, mcycle_reg, minstret_reg), fetch_unit (output enable); ALU inline.

Verification
REQ-033 Reset release, RESET_ADDRESS=0 -> first fetch address 0, enable high one cycle, mask 4'b1111.
REQ-034 ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 -> x3=2; x0 stays 0 after ADDI x0,x0,7.
REQ-035 x5=0x11223344, SB x5,1(x0) -> mask 4'b0100, data[15:8]=0x44; LB/LBU from byte with 0x80 -> 0xFFFFFF80 / 0x00000080.
REQ-036 DIV 7 by 0 -> 0xFFFFFFFF, REM -> 7; MUL 0x10000*0x10000 -> 0, MULHU -> 1.
REQ-037 BEQ taken -> next fetch at PC+offset; JALR to 0x101 -> PC 0x100, rd=PC+4.
REQ-038 SW to 0x1000_0000 with data 0x41 -> data enable, WRITE, address 0x1000_0000; EBREAK -> funct12_MW_reg=0x001, enables stay 0 afterwards.

Source files
------------

// File: rtl/phoenix_pkg.sv
// Shared constants and types for the phoenix RV32 multi-cycle core.
package phoenix_pkg;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [6:0]  FUNCT7_MULDIV  = 7'b0000001;
  localparam logic [11:0] FUNCT12_EBREAK = 12'h001;

  localparam logic READ    = 1'b0;
  localparam logic WRITE   = 1'b1;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_ALUCSR    = 12'h800;
  localparam logic [11:0] CSR_MULCSR    = 12'h801;
  localparam logic [11:0] CSR_DIVCSR    = 12'h802;

  typedef enum logic [2:0] {
    StFetch,
    StExecute,
    StMemory,
    StWriteback,
    StHalt
  } state_e;

  // Byte enables: lane k (bits 8k+7:8k) is enabled by mask bit 3-k.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3[1:0])
      2'b00:   lane_mask = 4'b1000 >> addr;
      2'b01:   lane_mask = addr[1] ? 4'b0011 : 4'b1100;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/control_status_register_file.sv
// Machine counters plus three scratch CSRs; unimplemented addresses read as zero.
module control_status_register_file
  import phoenix_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] read_address,
  output logic [31:0] read_data,
  input  logic        write_enable,
  input  logic [11:0] write_address,
  input  logic [31:0] write_data,
  input  logic        retire
);

  logic [31:0] alucsr_reg;
  logic [31:0] mulcsr_reg;
  logic [31:0] divcsr_reg;
  logic [63:0] mcycle_reg;
  logic [63:0] minstret_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      alucsr_reg   <= 32'h0;
      mulcsr_reg   <= 32'h0;
      divcsr_reg   <= 32'h0;
      mcycle_reg   <= 64'h0;
      minstret_reg <= 64'h0;
    end else begin
      mcycle_reg <= mcycle_reg + 64'd1;
      if (retire) minstret_reg <= minstret_reg + 64'd1;
      // An explicit write overrides the automatic increment of the same half.
      if (write_enable) begin
        case (write_address)
          CSR_MCYCLE:    mcycle_reg[31:0]    <= write_data;
          CSR_MCYCLEH:   mcycle_reg[63:32]   <= write_data;
          CSR_MINSTRET:  minstret_reg[31:0]  <= write_data;
          CSR_MINSTRETH: minstret_reg[63:32] <= write_data;
          CSR_ALUCSR:    alucsr_reg          <= write_data;
          CSR_MULCSR:    mulcsr_reg          <= write_data;
          CSR_DIVCSR:    divcsr_reg          <= write_data;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    read_data = 32'h0;
    case (read_address)
      CSR_MCYCLE:    read_data = mcycle_reg[31:0];
      CSR_MCYCLEH:   read_data = mcycle_reg[63:32];
      CSR_MINSTRET:  read_data = minstret_reg[31:0];
      CSR_MINSTRETH: read_data = minstret_reg[63:32];
      CSR_ALUCSR:    read_data = alucsr_reg;
      CSR_MULCSR:    read_data = mulcsr_reg;
      CSR_DIVCSR:    read_data = divcsr_reg;
      default:       read_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and instruction register; issues one read per FETCH cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  input  logic [31:0] instruction_data,
  output logic        enable,
  output logic [31:0] address,
  output logic [31:0] pc,
  output logic [31:0] instruction
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_ADDRESS;
      instruction <= 32'h0;
    end else begin
      if (fetch) instruction <= instruction_data;
      if (pc_write) pc <= pc_next;
    end
  end

  // Held low through reset even though the FSM already sits in FETCH.
  assign enable  = fetch & ~reset;
  assign address = pc;

endmodule

// File: rtl/register_file.sv
// Integer register file; x0 is hard-wired zero, RV32E hides x16-x31.
module register_file #(
  parameter bit E_EXTENSION = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_address,
  input  logic [4:0]  rs2_address,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        write_enable,
  input  logic [4:0]  rd_address,
  input  logic [31:0] rd_data
);

  logic [31:0] Registers [0:31];

  function automatic logic visible(input logic [4:0] address);
    visible = (address != 5'd0) && !(E_EXTENSION && address[4]);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) Registers[i] <= 32'h0;
    end else if (write_enable && visible(rd_address)) begin
      Registers[rd_address] <= rd_data;
    end
  end

  assign rs1_data = visible(rs1_address) ? Registers[rs1_address] : 32'h0;
  assign rs2_data = visible(rs2_address) ? Registers[rs2_address] : 32'h0;

endmodule

// File: rtl/phoenix.sv
// Multi-cycle RV32I(+M/E) core: FETCH -> EXECUTE -> [MEMORY] -> WRITEBACK, halting on EBREAK.
module phoenix
  import phoenix_pkg::*;
#(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000,
  parameter bit          M_EXTENSION   = 1'b0,
  parameter bit          E_EXTENSION   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        instruction_memory_interface_enable,
  output logic        instruction_memory_interface_state,
  output logic [31:0] instruction_memory_interface_address,
  output logic [3:0]  instruction_memory_interface_frame_mask,
  input  logic [31:0] instruction_memory_interface_data,
  output logic        data_memory_interface_enable,
  output logic        data_memory_interface_state,
  output logic [31:0] data_memory_interface_address,
  output logic [3:0]  data_memory_interface_frame_mask,
  inout  wire  [31:0] data_memory_interface_data
);

  state_e      state_q;
  logic [31:0] pc, instruction;
  logic [31:0] rs1_data, rs2_data, csr_read_data;
  logic [31:0] result_q, next_pc_q, mem_address_q, load_data_q, csr_wdata_q, store_data_q;
  logic        dmem_enable_q, dmem_state_q;
  logic [3:0]  dmem_mask_q;
  logic [6:0]  opcode_MW_reg;
  logic [11:0] funct12_MW_reg;

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [11:0] funct12;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode  = instruction[6:0];
  assign rd      = instruction[11:7];
  assign funct3  = instruction[14:12];
  assign rs1     = instruction[19:15];
  assign rs2     = instruction[24:20];
  assign funct7  = instruction[31:25];
  assign funct12 = instruction[31:20];
  assign imm_i   = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b   = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25],
                    instruction[11:8], 1'b0};
  assign imm_u   = {instruction[31:12], 12'h0};
  assign imm_j   = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20],
                    instruction[30:21], 1'b0};

  logic is_m_op, is_load, is_store, is_ebreak, rd_write, csr_write, retire;
  assign is_m_op   = (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
  assign is_load   = (opcode == OPCODE_LOAD);
  assign is_store  = (opcode == OPCODE_STORE);
  assign is_ebreak = (opcode == OPCODE_SYSTEM) && (funct3 == 3'b000) &&
                     (funct12 == FUNCT12_EBREAK);
  assign retire    = (state_q == StWriteback);

  fetch_unit #(
    .RESET_ADDRESS(RESET_ADDRESS)
  ) fetch_unit (
    .clk             (clk),
    .reset           (reset),
    .fetch           (state_q == StFetch),
    .pc_write        (retire),
    .pc_next         (next_pc_q),
    .instruction_data(instruction_memory_interface_data),
    .enable          (instruction_memory_interface_enable),
    .address         (instruction_memory_interface_address),
    .pc              (pc),
    .instruction     (instruction)
  );

  assign instruction_memory_interface_state      = READ;
  assign instruction_memory_interface_frame_mask = 4'b1111;

  logic [31:0] load_value, rf_write_data;
  assign rf_write_data = is_load ? load_value : result_q;

  register_file #(
    .E_EXTENSION(E_EXTENSION)
  ) register_file (
    .clk         (clk),
    .reset       (reset),
    .rs1_address (rs1),
    .rs2_address (rs2),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .write_enable(retire && rd_write),
    .rd_address  (rd),
    .rd_data     (rf_write_data)
  );

  control_status_register_file control_status_register_file (
    .clk          (clk),
    .reset        (reset),
    .read_address (funct12),
    .read_data    (csr_read_data),
    .write_enable (retire && csr_write),
    .write_address(funct12),
    .write_data   (csr_wdata_q),
    .retire       (retire)
  );

  // Base ALU
  logic [31:0] alu_b, alu_result;
  always_comb begin
    alu_b = (opcode == OPCODE_OP) ? rs2_data : imm_i;
    case (funct3)
      3'b000:  alu_result = ((opcode == OPCODE_OP) && funct7[5]) ? rs1_data - alu_b
                                                                  : rs1_data + alu_b;
      3'b001:  alu_result = rs1_data << alu_b[4:0];
      3'b010:  alu_result = {31'h0, $signed(rs1_data) < $signed(alu_b)};
      3'b011:  alu_result = {31'h0, rs1_data < alu_b};
      3'b100:  alu_result = rs1_data ^ alu_b;
      3'b101:  alu_result = funct7[5] ? 32'($signed(rs1_data) >>> alu_b[4:0])
                                      : rs1_data >> alu_b[4:0];
      3'b110:  alu_result = rs1_data | alu_b;
      default: alu_result = rs1_data & alu_b;
    endcase
  end

  // Multiply/divide; signed division goes through magnitudes so -2^31/-1 needs no special case.
  logic [63:0] mul_a, mul_b, product;
  logic [31:0] abs_a, abs_b, quot_mag, rem_mag, m_result;
  logic        signed_div, div_zero;
  always_comb begin
    mul_a      = {{32{(funct3 == 3'b001 || funct3 == 3'b010) && rs1_data[31]}}, rs1_data};
    mul_b      = {{32{(funct3 == 3'b001) && rs2_data[31]}}, rs2_data};
    product    = mul_a * mul_b;
    signed_div = ~funct3[0];
    abs_a      = (signed_div && rs1_data[31]) ? 32'(-rs1_data) : rs1_data;
    abs_b      = (signed_div && rs2_data[31]) ? 32'(-rs2_data) : rs2_data;
    div_zero   = (rs2_data == 32'h0);
    quot_mag   = div_zero ? 32'h0 : abs_a / abs_b;
    rem_mag    = div_zero ? 32'h0 : abs_a % abs_b;
    case (funct3)
      3'b000:  m_result = product[31:0];
      3'b001, 3'b010, 3'b011: m_result = product[63:32];
      3'b100:  m_result = div_zero ? 32'hFFFF_FFFF :
                          (rs1_data[31] ^ rs2_data[31]) ? 32'(-quot_mag) : quot_mag;
      3'b101:  m_result = div_zero ? 32'hFFFF_FFFF : quot_mag;
      3'b110:  m_result = div_zero ? rs1_data : rs1_data[31] ? 32'(-rem_mag) : rem_mag;
      default: m_result = div_zero ? rs1_data : rem_mag;
    endcase
  end

  logic [31:0] csr_operand, csr_new;
  logic [31:0] exec_result, next_pc, mem_address, store_data;
  logic        branch_taken;
  always_comb begin
    csr_operand = funct3[2] ? {27'h0, rs1} : rs1_data;
    case (funct3[1:0])
      2'b01:   csr_new = csr_operand;
      2'b10:   csr_new = csr_read_data | csr_operand;
      default: csr_new = csr_read_data & ~csr_operand;
    endcase
    // Set/clear with a zero source are pure reads.
    csr_write = (opcode == OPCODE_SYSTEM) && (funct3[1:0] != 2'b00) &&
                ((funct3[1:0] == 2'b01) || (rs1 != 5'd0));

    case (opcode)
      OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR,
      OPCODE_OP_IMM, OPCODE_LOAD: rd_write = 1'b1;
      OPCODE_OP:                  rd_write = !is_m_op || M_EXTENSION;
      OPCODE_SYSTEM:              rd_write = (funct3 != 3'b000) && (funct3 != 3'b100);
      default:                    rd_write = 1'b0;
    endcase

    case (opcode)
      OPCODE_LUI:                 exec_result = imm_u;
      OPCODE_AUIPC:               exec_result = pc + imm_u;
      OPCODE_JAL, OPCODE_JALR:    exec_result = pc + 32'd4;
      OPCODE_OP:                  exec_result = is_m_op ? m_result : alu_result;
      OPCODE_OP_IMM:              exec_result = alu_result;
      OPCODE_SYSTEM:              exec_result = csr_read_data;
      default:                    exec_result = 32'h0;
    endcase

    case (funct3)
      3'b000:  branch_taken = (rs1_data == rs2_data);
      3'b001:  branch_taken = (rs1_data != rs2_data);
      3'b100:  branch_taken = ($signed(rs1_data) < $signed(rs2_data));
      3'b101:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  branch_taken = (rs1_data < rs2_data);
      3'b111:  branch_taken = (rs1_data >= rs2_data);
      default: branch_taken = 1'b0;
    endcase

    if (opcode == OPCODE_JAL)                        next_pc = pc + imm_j;
    else if (opcode == OPCODE_JALR)                  next_pc = rs1_data + imm_i;
    else if (opcode == OPCODE_BRANCH && branch_taken) next_pc = pc + imm_b;
    else                                             next_pc = pc + 32'd4;
    next_pc[0] = 1'b0;

    mem_address = rs1_data + (is_store ? imm_s : imm_i);
    case (funct3[1:0])
      2'b00:   store_data = {4{rs2_data[7:0]}};
      2'b01:   store_data = {2{rs2_data[15:0]}};
      default: store_data = rs2_data;
    endcase
  end

  logic [31:0] byte_lane, half_lane;
  always_comb begin
    byte_lane = load_data_q >> {mem_address_q[1:0], 3'b000};
    half_lane = load_data_q >> {mem_address_q[1], 4'b0000};
    case (funct3)
      3'b000:  load_value = {{24{byte_lane[7]}}, byte_lane[7:0]};
      3'b001:  load_value = {{16{half_lane[15]}}, half_lane[15:0]};
      3'b100:  load_value = {24'h0, byte_lane[7:0]};
      3'b101:  load_value = {16'h0, half_lane[15:0]};
      default: load_value = load_data_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StFetch;
      result_q       <= 32'h0;
      next_pc_q      <= 32'h0;
      mem_address_q  <= 32'h0;
      load_data_q    <= 32'h0;
      csr_wdata_q    <= 32'h0;
      store_data_q   <= 32'h0;
      dmem_enable_q  <= DISABLE;
      dmem_state_q   <= READ;
      dmem_mask_q    <= 4'h0;
      opcode_MW_reg  <= 7'h0;
      funct12_MW_reg <= 12'h0;
    end else begin
      case (state_q)
        StFetch: state_q <= StExecute;
        StExecute: begin
          result_q      <= exec_result;
          next_pc_q     <= next_pc;
          mem_address_q <= mem_address;
          csr_wdata_q   <= csr_new;
          if (is_load || is_store) begin
            state_q       <= StMemory;
            dmem_enable_q <= ENABLE;
            dmem_state_q  <= is_store ? WRITE : READ;
            dmem_mask_q   <= lane_mask(funct3, mem_address[1:0]);
            store_data_q  <= store_data;
          end else begin
            state_q <= StWriteback;
          end
        end
        StMemory: begin
          load_data_q   <= data_memory_interface_data;
          dmem_enable_q <= DISABLE;
          dmem_state_q  <= READ;
          dmem_mask_q   <= 4'h0;
          state_q       <= StWriteback;
        end
        StWriteback: begin
          opcode_MW_reg  <= opcode;
          funct12_MW_reg <= funct12;
          state_q        <= is_ebreak ? StHalt : StFetch;
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StFetch;
      endcase
    end
  end

  assign data_memory_interface_enable     = dmem_enable_q;
  assign data_memory_interface_state      = dmem_state_q;
  assign data_memory_interface_address    = mem_address_q;
  assign data_memory_interface_frame_mask = dmem_mask_q;
  assign data_memory_interface_data       = (dmem_enable_q && dmem_state_q == WRITE) ?
                                            store_data_q : {32{1'bz}};

endmodule

// File: tb/tb_phoenix.sv
// Directed program run on phoenix with M enabled; checks bus traffic and architectural state.
module tb_phoenix;

  logic        clk = 1'b0;
  logic        reset;
  logic        ien, istate, den, dstate;
  logic [31:0] iaddr, idata, daddr;
  logic [3:0]  imask, dmask;
  wire  [31:0] dbus;

  logic [31:0] imem [0:127];
  logic [31:0] dmem [0:15] = '{default: 32'h0};
  logic [31:0] fetch_log [0:63];
  logic [31:0] st_addr [0:7];
  logic [31:0] st_data [0:7];
  logic [3:0]  st_mask [0:7];
  int          fetch_n = 0;
  int          st_n = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  phoenix #(
    .RESET_ADDRESS(32'h0000_0000),
    .M_EXTENSION  (1'b1),
    .E_EXTENSION  (1'b0)
  ) dut (
    .clk                                    (clk),
    .reset                                  (reset),
    .instruction_memory_interface_enable    (ien),
    .instruction_memory_interface_state     (istate),
    .instruction_memory_interface_address   (iaddr),
    .instruction_memory_interface_frame_mask(imask),
    .instruction_memory_interface_data      (idata),
    .data_memory_interface_enable           (den),
    .data_memory_interface_state            (dstate),
    .data_memory_interface_address          (daddr),
    .data_memory_interface_frame_mask       (dmask),
    .data_memory_interface_data             (dbus)
  );

  assign idata = imem[iaddr[8:2]];
  assign dbus  = (den && !dstate) ? dmem[daddr[5:2]] : {32{1'bz}};

  always @(posedge clk) begin
    if (!reset && ien) begin
      fetch_log[fetch_n[5:0]] <= iaddr;
      fetch_n <= fetch_n + 1;
    end
    if (!reset && den && dstate) begin
      st_addr[st_n[2:0]] <= daddr;
      st_mask[st_n[2:0]] <= dmask;
      st_data[st_n[2:0]] <= dbus;
      st_n <= st_n + 1;
      for (int k = 0; k < 4; k++)
        if (dmask[3-k]) dmem[daddr[5:2]][8*k +: 8] <= dbus[8*k +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    enc_i = {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    enc_r = {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    enc_s = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    enc_b = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [4:0] rd,
                                        input logic [6:0] op);
    enc_u = {imm20[19:0], rd, op};
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0013;
    imem[0]    = enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'h13);          // addi x1,x0,5
    imem[1]    = enc_i(-32'sd3, 5'd0, 3'd0, 5'd2, 7'h13);        // addi x2,x0,-3
    imem[2]    = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);           // add x3,x1,x2
    imem[3]    = enc_i(32'd7, 5'd0, 3'd0, 5'd0, 7'h13);          // addi x0,x0,7
    imem[4]    = enc_u(32'h11223, 5'd5, 7'h37);                  // lui x5
    imem[5]    = enc_i(32'h344, 5'd5, 3'd0, 5'd5, 7'h13);        // x5 = 0x11223344
    imem[6]    = enc_s(32'd1, 5'd5, 5'd0, 3'd0);                 // sb x5,1(x0)
    imem[7]    = enc_i(32'h80, 5'd0, 3'd0, 5'd6, 7'h13);         // addi x6,x0,0x80
    imem[8]    = enc_s(32'd2, 5'd6, 5'd0, 3'd0);                 // sb x6,2(x0)
    imem[9]    = enc_i(32'd2, 5'd0, 3'd0, 5'd7, 7'h03);          // lb x7,2(x0)
    imem[10]   = enc_i(32'd2, 5'd0, 3'd4, 5'd8, 7'h03);          // lbu x8,2(x0)
    imem[11]   = enc_b(32'd8, 5'd1, 5'd1, 3'd0);                 // beq x1,x1,+8
    imem[12]   = enc_i(32'd1, 5'd0, 3'd0, 5'd9, 7'h13);          // skipped
    imem[13]   = enc_i(32'h101, 5'd0, 3'd0, 5'd10, 7'h13);       // x10 = 0x101
    imem[14]   = enc_i(32'd0, 5'd10, 3'd0, 5'd11, 7'h67);        // jalr x11,0(x10)
    imem[8'h40] = enc_u(32'h10000, 5'd12, 7'h37);                // x12 = 0x10000000
    imem[8'h41] = enc_i(32'h41, 5'd0, 3'd0, 5'd13, 7'h13);       // x13 = 0x41
    imem[8'h42] = enc_s(32'd0, 5'd13, 5'd12, 3'd2);              // sw x13,0(x12)
    imem[8'h43] = enc_i(32'hB02, 5'd0, 3'd2, 5'd14, 7'h73);      // csrrs x14,minstret,x0
    imem[8'h44] = enc_i(32'd7, 5'd0, 3'd0, 5'd15, 7'h13);        // x15 = 7
    imem[8'h45] = enc_r(7'h01, 5'd0, 5'd15, 3'd4, 5'd16);        // div x16,x15,x0
    imem[8'h46] = enc_r(7'h01, 5'd0, 5'd15, 3'd6, 5'd17);        // rem x17,x15,x0
    imem[8'h47] = enc_u(32'h10, 5'd18, 7'h37);                   // x18 = 0x10000
    imem[8'h48] = enc_r(7'h01, 5'd18, 5'd18, 3'd0, 5'd19);       // mul
    imem[8'h49] = enc_r(7'h01, 5'd18, 5'd18, 3'd3, 5'd20);       // mulhu
    imem[8'h4A] = 32'h0010_0073;                                 // ebreak

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ifetch_en", {31'h0, ien}, 32'd0);
    check("reset_dmem_en", {31'h0, den}, 32'd0);
    check("reset_funct12_mw", {20'h0, dut.funct12_MW_reg}, 32'h0);

    reset = 1'b0;
    #1;
    check("first_fetch_en", {31'h0, ien}, 32'd1);
    check("first_fetch_addr", iaddr, 32'h0000_0000);
    check("first_fetch_mask", {28'h0, imask}, 32'hF);
    check("first_fetch_state", {31'h0, istate}, 32'd0);
    @(negedge clk);
    check("fetch_one_cycle", {31'h0, ien}, 32'd0);

    repeat (200) @(negedge clk);

    check("x1_addi", dut.register_file.Registers[1], 32'd5);
    check("x2_addi_neg", dut.register_file.Registers[2], 32'hFFFF_FFFD);
    check("x3_add", dut.register_file.Registers[3], 32'd2);
    check("x0_zero", dut.register_file.Registers[0], 32'd0);
    check("x5_lui_addi", dut.register_file.Registers[5], 32'h1122_3344);
    check("sb_addr", st_addr[0], 32'h0000_0001);
    check("sb_mask", {28'h0, st_mask[0]}, 32'h4);
    check("sb_lane_data", {24'h0, st_data[0][15:8]}, 32'h44);
    check("sb2_mask", {28'h0, st_mask[1]}, 32'h2);
    check("lb_sign", dut.register_file.Registers[7], 32'hFFFF_FF80);
    check("lbu_zero", dut.register_file.Registers[8], 32'h0000_0080);
    check("beq_target", fetch_log[12], 32'h0000_0034);
    check("beq_skipped", dut.register_file.Registers[9], 32'd0);
    check("jalr_target", fetch_log[14], 32'h0000_0100);
    check("jalr_link", dut.register_file.Registers[11], 32'h0000_003C);
    check("sw_addr", st_addr[2], 32'h1000_0000);
    check("sw_mask", {28'h0, st_mask[2]}, 32'hF);
    check("sw_data", st_data[2], 32'h0000_0041);
    check("store_count", st_n, 32'd3);
    check("csr_minstret", dut.register_file.Registers[14], 32'd17);
    check("div_by_zero", dut.register_file.Registers[16], 32'hFFFF_FFFF);
    check("rem_by_zero", dut.register_file.Registers[17], 32'd7);
    check("mul_low", dut.register_file.Registers[19], 32'd0);
    check("mulhu_high", dut.register_file.Registers[20], 32'd1);
    check("ebreak_funct12", {20'h0, dut.funct12_MW_reg}, 32'h001);
    check("ebreak_opcode", {25'h0, dut.opcode_MW_reg}, 32'h73);
    check("fetch_count", fetch_n, 32'd25);
    check("halt_ifetch_en", {31'h0, ien}, 32'd0);
    check("halt_dmem_en", {31'h0, den}, 32'd0);

    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_clears_x3", dut.register_file.Registers[3], 32'd0);
    check("reset_clears_opcode_mw", {25'h0, dut.opcode_MW_reg}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
